// File: rtl/baud_pkg.sv
// Package: baud_pkg
// Shared helpers for the fractional baud tick generator:
//   clogb2()            bits needed to hold a value (minimum 1)
//   phase_width()       width of the oversample phase counter for a given oversampling
//   default_div_int()   integer divisor loaded at reset
//   default_div_frac()  fractional divisor loaded at reset (NB_FRAC bits of fraction)
package baud_pkg;

  function automatic int clogb2(input longint unsigned value);
    int w;
    w = 1;
    while ((longint'(1) << w) <= value) w++;
    return w;
  endfunction

  function automatic int phase_width(input int unsigned ovs);
    return clogb2(longint'(ovs) - 1);
  endfunction

  function automatic longint unsigned default_div_int(input longint unsigned clk_freq,
                                                      input longint unsigned baud,
                                                      input longint unsigned ovs);
    return clk_freq / (baud * ovs);
  endfunction

  function automatic longint unsigned default_div_frac(input longint unsigned clk_freq,
                                                       input longint unsigned baud,
                                                       input longint unsigned ovs,
                                                       input int unsigned nb_frac);
    return ((clk_freq << nb_frac) / (baud * ovs)) % (longint'(1) << nb_frac);
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Module: baud_frac_acc
// Fractional-divisor accumulator. Each tick adds the active fraction to the
// accumulator; the overflow (carry) lengthens the following tick period by one cycle.
// Ports:
//   clk      clock
//   i_rst_n  asynchronous active-low reset
//   i_clear  synchronous clear of accumulator and carry (restart)
//   i_step   accumulate i_frac this cycle (tick boundary)
//   i_frac   active fractional divisor
//   o_carry  extra cycle for the current period
module baud_frac_acc #(
  parameter int NB_FRAC = 4
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_step,
  input  logic [NB_FRAC-1:0] i_frac,
  output logic               o_carry
);

  logic [NB_FRAC-1:0] r_acc;
  logic               r_carry;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_clear) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_step) begin
      {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, i_frac};
    end
  end

  assign o_carry = r_carry;

endmodule

// File: rtl/baud_tick_gen_frac.sv
// Module: baud_tick_gen_frac
// Oversampling tick generator for UART TX/RX. Divides clk by a runtime-programmable
// fixed-point divisor (integer + fraction) so the average baud rate is exact, and
// produces the oversample tick, bit-boundary tick, mid-bit tick and phase.
// Build option: define BAUD_TICK_FRAC_EN to include the fractional accumulator;
// without it the period is always the integer divisor and i_div_frac is ignored.
// Ports:
//   clk, i_rst_n        clock, asynchronous active-low reset
//   i_enable            1 = count, 0 = freeze counters (no ticks)
//   i_restart           synchronous restart of counter, accumulator and phase
//   i_div_int/_frac     new divisor, offered with i_div_valid / o_div_ready
//   o_div_err           1-cycle pulse when an offered divisor is rejected (int < 2)
//   o_tick              oversample tick
//   o_bit_tick          tick on which phase wraps to 0
//   o_mid_tick          tick on which phase reaches OVERSAMPLING/2
//   o_phase             ticks since the last bit boundary
module baud_tick_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 19200,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int          NB_INT       = 16,
  parameter int          NB_FRAC      = 4
) (
  input  logic                                  clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_enable,
  input  logic                                  i_restart,
  input  logic [NB_INT-1:0]                     i_div_int,
  input  logic [NB_FRAC-1:0]                    i_div_frac,
  input  logic                                  i_div_valid,
  output logic                                  o_div_ready,
  output logic                                  o_div_err,
  output logic                                  o_tick,
  output logic                                  o_bit_tick,
  output logic                                  o_mid_tick,
  output logic [phase_width(OVERSAMPLING)-1:0]  o_phase
);

  localparam int PHASE_W = phase_width(OVERSAMPLING);
  localparam logic [NB_INT-1:0] RST_DIV_INT =
    NB_INT'(default_div_int(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLING));

  logic [NB_INT-1:0]  r_cnt;
  logic [NB_INT-1:0]  r_div_int;
  logic [NB_INT-1:0]  r_pend_int;
  logic               r_pending;
  logic [PHASE_W-1:0] r_phase;
  logic               r_tick;
  logic               r_bit_tick;
  logic               r_mid_tick;
  logic               r_div_err;

  logic               w_carry;
  logic [NB_INT:0]    w_period_m1;
  logic               w_terminal;
  logic               w_step;
  logic               w_offer;
  logic               w_capture;
  logic               w_reject;
  logic               w_apply;
  logic [PHASE_W-1:0] w_phase_nxt;

  // Period is div_int + carry. The >= compare keeps a freshly shortened divisor
  // from letting the counter run past its new terminal count.
  assign w_period_m1 = {1'b0, r_div_int} + {{NB_INT{1'b0}}, w_carry} - (NB_INT + 1)'(1);
  assign w_terminal  = ({1'b0, r_cnt} >= w_period_m1);
  assign w_step      = ~i_restart & i_enable & w_terminal;

  assign w_offer   = i_div_valid & ~r_pending;
  assign w_capture = w_offer & (i_div_int >= NB_INT'(2));
  assign w_reject  = w_offer & (i_div_int <  NB_INT'(2));
  // A pending divisor waits for the tick boundary, unless the counter is frozen
  // or being restarted, in which case there is no period to protect.
  assign w_apply   = r_pending & (i_restart | ~i_enable | w_terminal);

  assign w_phase_nxt = (r_phase == PHASE_W'(OVERSAMPLING - 1)) ? '0 : r_phase + PHASE_W'(1);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_div_int  <= RST_DIV_INT;
      r_pend_int <= '0;
      r_pending  <= 1'b0;
      r_phase    <= '0;
      r_tick     <= 1'b0;
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
      r_div_err  <= w_reject;

      if (w_capture) begin
        r_pend_int <= i_div_int;
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_div_int <= r_pend_int;
        r_pending <= 1'b0;
      end

      if (i_restart) begin
        r_cnt   <= '0;
        r_phase <= '0;
      end else if (i_enable) begin
        if (w_terminal) begin
          r_cnt      <= '0;
          r_tick     <= 1'b1;
          r_phase    <= w_phase_nxt;
          r_bit_tick <= (w_phase_nxt == '0);
          r_mid_tick <= (w_phase_nxt == PHASE_W'(OVERSAMPLING / 2));
        end else begin
          r_cnt <= r_cnt + NB_INT'(1);
        end
      end
    end
  end

`ifdef BAUD_TICK_FRAC_EN
  localparam logic [NB_FRAC-1:0] RST_DIV_FRAC =
    NB_FRAC'(default_div_frac(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLING, NB_FRAC));

  logic [NB_FRAC-1:0] r_div_frac;
  logic [NB_FRAC-1:0] r_pend_frac;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_frac  <= RST_DIV_FRAC;
      r_pend_frac <= '0;
    end else begin
      if (w_capture) r_pend_frac <= i_div_frac;
      else if (w_apply) r_div_frac <= r_pend_frac;
    end
  end

  // The tick that closes a period steps with the fraction that was active for it.
  baud_frac_acc #(
    .NB_FRAC (NB_FRAC)
  ) u_frac_acc (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_restart),
    .i_step  (w_step),
    .i_frac  (r_div_frac),
    .o_carry (w_carry)
  );
`else
  logic w_unused_frac;
  assign w_unused_frac = ^{i_div_frac, w_step};
  assign w_carry       = 1'b0;
`endif

  assign o_div_ready = ~r_pending;
  assign o_div_err   = r_div_err;
  assign o_tick      = r_tick;
  assign o_bit_tick  = r_bit_tick;
  assign o_mid_tick  = r_mid_tick;
  assign o_phase     = r_phase;

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
`timescale 1ns/1ps
module tb_baud_tick_gen_frac;

  localparam int NB_INT  = 16;
  localparam int NB_FRAC = 4;
  localparam int OVS     = 16;
`ifdef BAUD_TICK_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
  localparam int EXP_BIT = 2604;   // 16*162 + 12 carries per 16 ticks
`else
  localparam bit FRAC_EN = 1'b0;
  localparam int EXP_BIT = 2592;   // 16*162
`endif

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_enable = 1'b1;
  logic              i_restart = 1'b0;
  logic [NB_INT-1:0] i_div_int = '0;
  logic [NB_FRAC-1:0] i_div_frac = '0;
  logic              i_div_valid = 1'b0;
  logic              o_div_ready;
  logic              o_div_err;
  logic              o_tick;
  logic              o_bit_tick;
  logic              o_mid_tick;
  logic [3:0]        o_phase;

  baud_tick_gen_frac #(
    .CLK_FREQ     (50_000_000),
    .DEFAULT_BAUD (19200),
    .OVERSAMPLING (OVS),
    .NB_INT       (NB_INT),
    .NB_FRAC      (NB_FRAC)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_restart   (i_restart),
    .i_div_int   (i_div_int),
    .i_div_frac  (i_div_frac),
    .i_div_valid (i_div_valid),
    .o_div_ready (o_div_ready),
    .o_div_err   (o_div_err),
    .o_tick      (o_tick),
    .o_bit_tick  (o_bit_tick),
    .o_mid_tick  (o_mid_tick),
    .o_phase     (o_phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int sum_n;

  // Reference model of the active divisor and fraction accumulator.
  int m_int, m_frac, m_acc, m_carry, m_pint, m_pfrac;
  bit m_pend;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_int   = 162;
    m_frac  = FRAC_EN ? 12 : 0;
    m_acc   = 0;
    m_carry = 0;
    m_pend  = 1'b0;
  endtask

  task automatic m_step();
    int s;
    s       = m_acc + m_frac;
    m_carry = s / (1 << NB_FRAC);
    m_acc   = s % (1 << NB_FRAC);
    if (m_pend) begin
      m_int  = m_pint;
      m_frac = FRAC_EN ? m_pfrac : 0;
      m_pend = 1'b0;
    end
  endtask

  task automatic wait_tick(output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = (o_tick === 1'b1);
    end
  endtask

  // pre: cycles already elapsed since the previous tick; extra: expected stretch.
  task automatic next_tick(input string tag, input int pre, input int extra);
    int n;
    bit seen;
    wait_tick(n, seen);
    check(tag, seen ? pre + n : -1, m_int + m_carry + extra);
    sum_n += pre + n;
    m_step();
  endtask

  task automatic run_ticks(input string tag, input int count, input int ph0);
    int ph;
    for (int k = 1; k <= count; k++) begin
      next_tick($sformatf("%s_space%0d", tag, k), 0, 0);
      ph = (ph0 + k) % OVS;
      check($sformatf("%s_phase%0d", tag, k), o_phase, ph);
      check($sformatf("%s_bit%0d", tag, k), o_bit_tick, (ph == 0) ? 1 : 0);
      check($sformatf("%s_mid%0d", tag, k), o_mid_tick, (ph == OVS / 2) ? 1 : 0);
    end
  endtask

  task automatic wait_bit(output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = (o_bit_tick === 1'b1);
    end
  endtask

  initial begin
    int n;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tick",  o_tick, 0);
    check("rst_bit",   o_bit_tick, 0);
    check("rst_mid",   o_mid_tick, 0);
    check("rst_phase", o_phase, 0);
    check("rst_ready", o_div_ready, 1);
    check("rst_err",   o_div_err, 0);
    i_rst_n = 1'b1;
    m_reset();

    // Default divisor: 162 (+ fractional carries), bit interval
    sum_n = 0;
    run_ticks("t1", 16, 0);
    sum_n = 0;
    run_ticks("t1b", 16, 0);
    check("t1_bit_interval", sum_n, EXP_BIT);

    // Load int=4 mid-period: held pending until the tick boundary
    repeat (50) @(negedge clk);
    check("t2_ready_before", o_div_ready, 1);
    i_div_valid = 1'b1;
    i_div_int   = 16'd4;
    i_div_frac  = 4'd0;
    @(negedge clk);
    i_div_valid = 1'b0;
    check("t2_ready_low", o_div_ready, 0);
    m_pend = 1'b1; m_pint = 4; m_pfrac = 0;
    next_tick("t2_hold_period", 51, 0);
    check("t2_ready_back", o_div_ready, 1);
    for (int k = 1; k <= 4; k++) next_tick($sformatf("t2_space%0d", k), 0, 0);
    wait_bit(n, seen);
    check("t2_bit_seen", seen, 1);
    wait_bit(n, seen);
    check("t2_bit_interval", seen ? n : -1, 64);

    // Rejected divisor int=1
    i_div_valid = 1'b1;
    i_div_int   = 16'd1;
    @(negedge clk);
    i_div_valid = 1'b0;
    check("t3_err_pulse", o_div_err, 1);
    check("t3_ready_high", o_div_ready, 1);
    @(negedge clk);
    check("t3_err_cleared", o_div_err, 0);
    next_tick("t3_space_a", 2, 0);
    next_tick("t3_space_b", 0, 0);

    // Back to 162/12, then restart at cnt=100
    i_div_valid = 1'b1;
    i_div_int   = 16'd162;
    i_div_frac  = 4'd12;
    @(negedge clk);
    i_div_valid = 1'b0;
    check("t4_ready_low", o_div_ready, 0);
    m_pend = 1'b1; m_pint = 162; m_pfrac = 12;
    next_tick("t4_load_period", 1, 0);
    check("t4_ready_back", o_div_ready, 1);
    next_tick("t4_full_period", 0, 0);
    check("t4_phase_pre", o_phase, 4);
    repeat (100) @(negedge clk);
    i_restart = 1'b1;
    @(negedge clk);
    i_restart = 1'b0;
    check("t4_restart_phase", o_phase, 0);
    check("t4_restart_tick", o_tick, 0);
    m_acc = 0; m_carry = 0;
    run_ticks("t4", 16, 0);

    // Enable low for 10 cycles mid-period, with an immediately-applied divisor
    next_tick("t5_pre", 0, 0);
    repeat (40) @(negedge clk);
    i_enable    = 1'b0;
    i_div_valid = 1'b1;
    i_div_int   = 16'd162;
    i_div_frac  = 4'd12;
    @(negedge clk);
    i_div_valid = 1'b0;
    check("t5_ready_low", o_div_ready, 0);
    check("t5_tick_off0", o_tick, 0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) check("t5_ready_immediate", o_div_ready, 1);
      check($sformatf("t5_tick_off%0d", k), o_tick, 0);
    end
    check("t5_phase_held", o_phase, 1);
    i_enable = 1'b1;
    next_tick("t5_stretched", 50, 10);
    check("t5_phase_after", o_phase, 2);

    // Async reset mid-period discards a pending divisor
    repeat (30) @(negedge clk);
    i_div_valid = 1'b1;
    i_div_int   = 16'd4;
    i_div_frac  = 4'd0;
    @(negedge clk);
    i_div_valid = 1'b0;
    check("t6_ready_low", o_div_ready, 0);
    #2 i_rst_n = 1'b0;
    #1;
    check("t6_async_ready", o_div_ready, 1);
    check("t6_async_phase", o_phase, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    m_reset();
    next_tick("t6_first", 0, 0);
    check("t6_ready", o_div_ready, 1);
    next_tick("t6_second", 0, 0);
    next_tick("t6_third", 0, 0);
    check("t6_phase", o_phase, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
